match_scheduler: RTL
====================

Name: match_scheduler

Overview:
- Sequences one string_match engine over a sequence of strings against a table of up to NBATCH keyword batches.
- Per string: waits for string_ready, then issues each batch in turn with weight_enable, waits for done, and drives string_finish on the last batch.
- Captures the engine's result vector once per string and reports it to the host with a valid pulse.

Parameters:
DWIDTH, 8, bits per character/weight byte
LANES, 16, engine lanes (groups*num); width of weight/len vectors
NBATCH, 4, batch table depth; power of 2
RES_W, 302, engine result width
TO_CYC, 1024, watchdog limit in cycles (optional feature only)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
cfg_we  input  1  write batch entry at cfg_addr
cfg_addr  input  log2(NBATCH)  batch index
cfg_weight  input  LANES*DWIDTH  lane-packed weight bytes
cfg_len  input  LANES*8  keyword lengths
cfg_count  input  8  keyword count of batch
num_batches  input  log2(NBATCH)+1  active batches, 1..NBATCH; sampled at start
num_strings  input  16  strings to process, sampled at start
start  input  1  run pulse; honoured only in IDLE
string_ready  input  1  engine string-loaded pulse
done  input  1  engine batch-complete level
result  input  RES_W  engine result
weight_enable  output  1  batch issue pulse
weight  output  LANES*DWIDTH  current batch weights
len_arr  output  LANES*8  current batch lengths
weight_count  output  8  current batch count
string_finish  output  1  high while the last batch is active
res_data  output  RES_W  captured per-string result
res_valid  output  1  one-cycle pulse with res_data
str_idx  output  16  strings completed
busy  output  1  not IDLE
error  output  1  sticky config/timeout error

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; FSM=IDLE; batch_idx=0. Table contents are not reset.
- Table: cfg_we writes all three fields in 1 cycle. Writes while busy=1 are ignored and set error.
- States: IDLE, WAIT_STR, ISSUE, WAIT_DONE, NEXT, FIN.
- IDLE: on start, latch num_batches/num_strings.
  - num_batches==0 or >NBATCH, or num_strings==0: set error, stay IDLE.
  - Otherwise go to WAIT_STR with str_idx=0 and batch_idx=0.
- WAIT_STR: on string_ready go to ISSUE. string_ready in any other state is ignored.
- ISSUE: weight/len_arr/weight_count are registered from table[batch_idx] one cycle before weight_enable and held stable until the next ISSUE. Assert weight_enable for exactly 1 cycle, then go to WAIT_DONE.
- string_finish = (batch_idx == num_batches-1) as a registered level, valid from ISSUE through the done cycle. The engine samples it in its done cycle.
- WAIT_DONE: on done=1 go to NEXT.
  - If this is the last batch, capture result into res_data and pulse res_valid in the same cycle.
  - done is edge-qualified: a level held across 2 cycles counts once.
- NEXT:
  - Not last batch: batch_idx++, go to ISSUE. The engine returns to accept weight_enable; issue no earlier than 1 cycle after done falls.
  - Last batch: batch_idx=0, str_idx++.
  - If str_idx now equals num_strings, go to FIN; else go to WAIT_STR.
- FIN: busy drops; return to IDLE after 1 cycle.
- start while busy is ignored. A reset mid-run aborts immediately with no res_valid.
- str_idx is 16-bit and never wraps, because num_strings bounds it.

Optional Feature:
MATCH_SCHED_TIMEOUT_EN
- Defined: 16-bit counter runs in WAIT_DONE and WAIT_STR, clears on state exit. At TO_CYC the block sets error, emits no res_valid, and goes to FIN.
- Undefined: no counter; the block waits indefinitely; error is only for config faults.

Decomposition:
- Package match_sched_pkg: state enum, LANES/DWIDTH/RES_W defaults, batch-entry struct {weight, len, count}.
- One sub-module match_batch_table: NBATCH-deep register file, sync write, registered read.

Test Plan:
- Load 2 batches (counts 3,5), num_batches=2, num_strings=1, start, string_ready → weight_enable twice. string_finish=0 for the first done and 1 for the second. One res_valid with the result sampled at the second done; str_idx=1.
- num_strings=3, num_batches=1 → three string_ready/done cycles. res_valid ×3, str_idx=3, busy low afterwards.
- start with num_batches=0 → error=1, busy stays 0.
- cfg_we during WAIT_DONE → table unchanged (readback on the next run matches the old data), error=1.
- done held for 3 cycles → batch advances only once.
- With MATCH_SCHED_TIMEOUT_EN and TO_CYC=16, done never asserted → error at cycle 16 of WAIT_DONE, FIN, no res_valid. reset low mid-WAIT_DONE → all outputs 0 immediately.

Source files
------------

// File: rtl/match_scheduler_pkg.sv
// match_sched_pkg: shared types and default sizes for the match_scheduler slice.
package match_sched_pkg;
  localparam int DWIDTH   = 8;
  localparam int LANES    = 16;
  localparam int RES_W    = 302;
  localparam int NBATCH_D = 4;
  localparam int TO_CYC_D = 1024;
  typedef enum logic [2:0] {IDLE, WAIT_STR, ISSUE, WAIT_DONE, NEXT, FIN} state_t;
  typedef struct packed {
    logic [LANES*DWIDTH-1:0] weight;
    logic [LANES*8-1:0]      len;
    logic [7:0]              count;
  } batch_t;
endpackage

// File: rtl/match_scheduler_if.sv
// match_scheduler_if: handshake between the scheduler (master) and one string_match engine (slave).
interface match_scheduler_if;
  import match_sched_pkg::*;
  logic                    string_ready;
  logic                    done;
  logic [RES_W-1:0]        result;
  logic                    weight_enable;
  logic [LANES*DWIDTH-1:0] weight;
  logic [LANES*8-1:0]      len_arr;
  logic [7:0]              weight_count;
  logic                    string_finish;
  modport master (input string_ready, done, result,
                  output weight_enable, weight, len_arr, weight_count, string_finish);
  modport slave  (output string_ready, done, result,
                  input weight_enable, weight, len_arr, weight_count, string_finish);
endinterface

// File: rtl/match_scheduler_batch_table.sv
// match_batch_table: NBATCH-deep keyword batch register file, sync write, registered read, not reset.
module match_batch_table
  import match_sched_pkg::*;
#(
  parameter int  NBATCH = NBATCH_D,
  localparam int AW     = $clog2(NBATCH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  batch_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output batch_t        rdata_o
);
  batch_t mem_q [NBATCH];
  batch_t rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/match_scheduler.sv
// match_scheduler: sequences one string_match engine over strings x keyword batches.
// Optional watchdog on WAIT_STR/WAIT_DONE enabled by `define MATCH_SCHED_TIMEOUT_EN.
module match_scheduler
  import match_sched_pkg::*;
#(
  parameter int NBATCH = NBATCH_D
`ifdef MATCH_SCHED_TIMEOUT_EN
  , parameter int TO_CYC = TO_CYC_D
`endif
  , localparam int AW = $clog2(NBATCH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [LANES*DWIDTH-1:0] cfg_weight,
  input  logic [LANES*8-1:0]      cfg_len,
  input  logic [7:0]              cfg_count,
  input  logic [AW:0]             num_batches,
  input  logic [15:0]             num_strings,
  input  logic                    start,
  match_scheduler_if.master       eng,
  output logic [RES_W-1:0]        res_data,
  output logic                    res_valid,
  output logic [15:0]             str_idx,
  output logic                    busy,
  output logic                    error
);
  localparam logic [AW:0] NB_MAX = (AW+1)'(NBATCH);
  state_t           state_q;
  logic             ph_q, done_q, we_q, sf_q, rv_q, busy_q, err_q;
  logic [AW-1:0]    bidx_q, raddr;
  logic [AW:0]      nb_q;
  logic [15:0]      ns_q, str_q;
  logic [RES_W-1:0] res_q;
  batch_t           cur_q, rd;
  logic             done_rise, last, to_hit;
  assign done_rise = eng.done & ~done_q;
  assign last      = {1'b0, bidx_q} == nb_q - 1'b1;
  // prefetch the following batch while in NEXT so ISSUE sees it after the read latency
  assign raddr     = (state_q == NEXT && !last) ? bidx_q + 1'b1 : bidx_q;
  match_batch_table #(.NBATCH(NBATCH)) u_tbl (
    .clk     (clk),
    .we_i    (cfg_we & ~busy_q),
    .waddr_i (cfg_addr),
    .wdata_i (batch_t'{cfg_weight, cfg_len, cfg_count}),
    .raddr_i (raddr),
    .rdata_o (rd)
  );
`ifdef MATCH_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        waiting, leave;
  assign waiting = state_q inside {WAIT_STR, WAIT_DONE};
  assign to_hit  = waiting && to_cnt_q == 16'(TO_CYC - 1);
  assign leave   = (state_q == WAIT_STR && eng.string_ready) || (state_q == WAIT_DONE && done_rise) || to_hit;
  always_ff @(posedge clk or negedge reset)
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= (waiting && !leave) ? to_cnt_q + 16'd1 : '0;
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      {ph_q, done_q, we_q, sf_q, rv_q, busy_q, err_q} <= '0;
      bidx_q  <= '0;
      nb_q    <= '0;
      ns_q    <= '0;
      str_q   <= '0;
      res_q   <= '0;
      cur_q   <= '0;
    end else begin
      done_q <= eng.done;
      we_q   <= 1'b0;
      rv_q   <= 1'b0;
      if (cfg_we && busy_q) err_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          if (num_batches == '0 || num_batches > NB_MAX || num_strings == '0) err_q <= 1'b1;
          else begin
            nb_q    <= num_batches;
            ns_q    <= num_strings;
            str_q   <= '0;
            bidx_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT_STR;
          end
        end
        WAIT_STR: if (eng.string_ready) state_q <= ISSUE;
          else if (to_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end
        ISSUE: begin
          ph_q <= ~ph_q;
          if (!ph_q) begin
            cur_q <= rd;
            sf_q  <= last;
          end else begin
            we_q    <= 1'b1;
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: if (done_rise) begin
            state_q <= NEXT;
            if (last) begin
              res_q <= eng.result;
              rv_q  <= 1'b1;
            end
          end else if (to_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end
        NEXT: if (last) begin
            bidx_q <= '0;
            str_q  <= str_q + 16'd1;
            sf_q   <= 1'b0;
            busy_q <= str_q + 16'd1 != ns_q;
            state_q <= (str_q + 16'd1 == ns_q) ? FIN : WAIT_STR;
          end else if (!eng.done) begin
            bidx_q  <= bidx_q + 1'b1;
            state_q <= ISSUE;
          end
        FIN: begin
          sf_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign eng.weight_enable = we_q;
  assign eng.weight        = cur_q.weight;
  assign eng.len_arr       = cur_q.len;
  assign eng.weight_count  = cur_q.count;
  assign eng.string_finish = sf_q;
  assign res_data          = res_q;
  assign res_valid         = rv_q;
  assign str_idx           = str_q;
  assign busy              = busy_q;
  assign error             = err_q;
endmodule
